// File: rtl/intersection_scheduler.sv
// Two-road intersection scheduler with round-robin grant among road A, road B and a pedestrian walk.
// Optional emergency preemption is compiled in with the EMERGENCY_PREEMPT_EN macro.
module intersection_scheduler #(
  parameter int MIN_GREEN    = 2,
  parameter int MAX_GREEN    = 5,
  parameter int YELLOW_TIME  = 1,
  parameter int ALL_RED_TIME = 1,
  parameter int WALK_TIME    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       ped_btn,
  input  logic       emerg,
  output logic [1:0] light_a,
  output logic [1:0] light_b,
  output logic       ped_light,
  output logic       ped_pending,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    A_GREEN  = 3'd1,
    A_YELLOW = 3'd2,
    B_GREEN  = 3'd3,
    B_YELLOW = 3'd4,
    PED_WALK = 3'd5
  } phase_e;

  typedef enum logic [1:0] {
    SRV_A = 2'd0,
    SRV_B = 2'd1,
    SRV_P = 2'd2
  } srv_e;

  localparam logic [1:0] L_RED    = 2'b00;
  localparam logic [1:0] L_YELLOW = 2'b01;
  localparam logic [1:0] L_GREEN  = 2'b10;

  localparam logic [7:0] MING_M1 = 8'(MIN_GREEN - 1);
  localparam logic [7:0] MAXG_M1 = 8'(MAX_GREEN - 1);
  localparam logic [7:0] YEL_M1  = 8'(YELLOW_TIME - 1);
  localparam logic [7:0] ARED_M1 = 8'(ALL_RED_TIME - 1);
  localparam logic [7:0] WALK_M1 = 8'(WALK_TIME - 1);

  logic [2:0] phase_q, phase_d;
  logic [7:0] timer_q, timer_d;
  logic       pa_q, pa_d, pb_q, pb_d, pp_q, pp_d;
  logic [1:0] last_q, last_d;
  logic [1:0] grant;
  logic       emerg_eff;

`ifdef EMERGENCY_PREEMPT_EN
  assign emerg_eff = emerg;
`else
  logic emerg_unused;
  assign emerg_unused = emerg;
  assign emerg_eff    = 1'b0;
`endif

  // Round-robin: first pending requester after the last one served.
  always_comb begin
    grant = SRV_A;
    case (last_q)
      SRV_A:   grant = pb_q ? SRV_B : (pp_q ? SRV_P : SRV_A);
      SRV_B:   grant = pp_q ? SRV_P : (pa_q ? SRV_A : SRV_B);
      default: grant = pa_q ? SRV_A : (pb_q ? SRV_B : SRV_P);
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    last_d  = last_q;
    case (phase_q)
      ALL_RED: begin
        if (timer_q >= ARED_M1 && !emerg_eff && (pa_q || pb_q || pp_q)) begin
          last_d = grant;
          case (grant)
            SRV_A:   phase_d = A_GREEN;
            SRV_B:   phase_d = B_GREEN;
            default: phase_d = PED_WALK;
          endcase
        end
      end
      A_GREEN: begin
        if (emerg_eff || ((pb_q || pp_q) && (timer_q >= MING_M1 || timer_q >= MAXG_M1)))
          phase_d = A_YELLOW;
      end
      A_YELLOW: if (timer_q >= YEL_M1) phase_d = ALL_RED;
      B_GREEN: begin
        if (emerg_eff || ((pa_q || pp_q) && (timer_q >= MING_M1 || timer_q >= MAXG_M1)))
          phase_d = B_YELLOW;
      end
      B_YELLOW: if (timer_q >= YEL_M1) phase_d = ALL_RED;
      PED_WALK: if (emerg_eff || timer_q >= WALK_M1) phase_d = ALL_RED;
      default:  phase_d = ALL_RED;
    endcase
  end

  // A request seen in the entry cycle survives the clear, so set wins.
  always_comb begin
    pa_d = req_a   | (pa_q & ~(phase_d == A_GREEN  && phase_q != A_GREEN));
    pb_d = req_b   | (pb_q & ~(phase_d == B_GREEN  && phase_q != B_GREEN));
    pp_d = ped_btn | (pp_q & ~(phase_d == PED_WALK && phase_q != PED_WALK));
    if (phase_d != phase_q)  timer_d = 8'd0;
    else if (timer_q == 8'hFF) timer_d = timer_q;
    else                     timer_d = timer_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= ALL_RED;
      timer_q <= 8'd0;
      pa_q    <= 1'b0;
      pb_q    <= 1'b0;
      pp_q    <= 1'b0;
      last_q  <= SRV_P;
    end else begin
      phase_q <= phase_d;
      timer_q <= timer_d;
      pa_q    <= pa_d;
      pb_q    <= pb_d;
      pp_q    <= pp_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    light_a = L_RED;
    light_b = L_RED;
    if (phase_q == A_GREEN)  light_a = L_GREEN;
    if (phase_q == A_YELLOW) light_a = L_YELLOW;
    if (phase_q == B_GREEN)  light_b = L_GREEN;
    if (phase_q == B_YELLOW) light_b = L_YELLOW;
  end

  assign ped_light   = (phase_q == PED_WALK);
  assign ped_pending = pp_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler (default parameters).
// Build with EMERGENCY_PREEMPT_EN defined to exercise the preemption scenario instead of the ignore scenario.
module tb_intersection_scheduler;

  logic       clk = 1'b0;
  logic       rst, req_a, req_b, ped_btn, emerg;
  logic [1:0] light_a, light_b;
  logic       ped_light, ped_pending;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  intersection_scheduler dut (
    .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .ped_btn(ped_btn),
    .emerg(emerg), .light_a(light_a), .light_b(light_b), .ped_light(ped_light),
    .ped_pending(ped_pending), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench one step after a reset edge with rst released: this is cycle 0.
  task automatic do_reset();
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_btn = 1'b0; emerg = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 1'b1; req_b = 1'b1; ped_btn = 1'b1; emerg = 1'b0;
    tick();
    tick();
    n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL reset_phase got %0d exp 0", phase); end
    n_tests++; if (light_a !== 2'b00) begin n_fail++; $display("FAIL reset_light_a got %b exp 00", light_a); end
    n_tests++; if (light_b !== 2'b00) begin n_fail++; $display("FAIL reset_light_b got %b exp 00", light_b); end
    n_tests++; if (ped_light !== 1'b0) begin n_fail++; $display("FAIL reset_ped_light got %b exp 0", ped_light); end
    n_tests++; if (ped_pending !== 1'b0) begin n_fail++; $display("FAIL reset_ped_pending got %b exp 0", ped_pending); end
    n_tests++; if (dut.timer_q !== 8'd0) begin n_fail++; $display("FAIL reset_timer got %0d exp 0", dut.timer_q); end
    rst = 1'b0; req_a = 1'b0; req_b = 1'b0; ped_btn = 1'b0;
  endtask

  task automatic test_first_grant();
    do_reset();
    req_a = 1'b1;
    n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL first_c0_phase got %0d exp 0", phase); end
    tick();
    n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL first_c1_phase got %0d exp 0", phase); end
    tick();
    n_tests++; if (light_a !== 2'b10) begin n_fail++; $display("FAIL first_c2_light_a got %b exp 10", light_a); end
    req_a = 1'b0;
  endtask

  task automatic test_min_green();
    logic [2:0] exp_ph [5] = '{3'd1, 3'd1, 3'd2, 3'd0, 3'd3};
    do_reset();
    req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    req_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (phase !== exp_ph[i]) begin n_fail++; $display("FAIL min_green_step%0d phase got %0d exp %0d", i, phase, exp_ph[i]); end
      if (i < 4) tick();
    end
    n_tests++; if (light_b !== 2'b10) begin n_fail++; $display("FAIL min_green_light_b got %b exp 10", light_b); end
    req_b = 1'b0;
  endtask

  task automatic test_long_hold();
    int bad = 0;
    do_reset();
    req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (light_a !== 2'b10) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL long_hold_green got %0d non-green cycles exp 0", bad); end
    repeat (260) tick();
    n_tests++; if (light_a !== 2'b10) begin n_fail++; $display("FAIL long_hold_late_green got %b exp 10", light_a); end
    n_tests++; if (dut.timer_q !== 8'd255) begin n_fail++; $display("FAIL long_hold_timer got %0d exp 255", dut.timer_q); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_ph [14] = '{3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd0, 3'd3,
                                3'd3, 3'd4, 3'd0, 3'd5, 3'd5, 3'd5, 3'd0};
    int walk = 0;
    int clash = 0;
    do_reset();
    req_a = 1'b1; req_b = 1'b1; ped_btn = 1'b1;
    for (int i = 0; i < 14; i++) begin
      n_tests++;
      if (phase !== exp_ph[i]) begin n_fail++; $display("FAIL rotation_c%0d phase got %0d exp %0d", i, phase, exp_ph[i]); end
      if (ped_light === 1'b1) walk++;
      if (((light_a != 2'b00) ? 1 : 0) + ((light_b != 2'b00) ? 1 : 0) + (ped_light ? 1 : 0) > 1) clash++;
      tick();
      req_a = 1'b0; req_b = 1'b0; ped_btn = 1'b0;
    end
    n_tests++; if (walk != 3) begin n_fail++; $display("FAIL rotation_walk_cycles got %0d exp 3", walk); end
    n_tests++; if (clash != 0) begin n_fail++; $display("FAIL rotation_exclusive got %0d conflicting cycles exp 0", clash); end
  endtask

  task automatic test_ped_relatch_and_reset();
    do_reset();
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    tick();
    n_tests++; if (ped_light !== 1'b1) begin n_fail++; $display("FAIL ped_walk_light got %b exp 1", ped_light); end
    n_tests++; if (ped_pending !== 1'b0) begin n_fail++; $display("FAIL ped_walk_cleared got %b exp 0", ped_pending); end
    ped_btn = 1'b1;
    tick();
    ped_btn = 1'b0;
    n_tests++; if (ped_pending !== 1'b1) begin n_fail++; $display("FAIL ped_relatch got %b exp 1", ped_pending); end
    tick();
    tick();
    n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL ped_clearance phase got %0d exp 0", phase); end
    tick();
    n_tests++; if (phase !== 3'd5) begin n_fail++; $display("FAIL ped_second_walk phase got %0d exp 5", phase); end
    rst = 1'b1; ped_btn = 1'b1;
    tick();
    rst = 1'b0; ped_btn = 1'b0;
    n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL walk_reset phase got %0d exp 0", phase); end
    n_tests++; if (ped_light !== 1'b0) begin n_fail++; $display("FAIL walk_reset ped_light got %b exp 0", ped_light); end
    n_tests++; if (ped_pending !== 1'b0) begin n_fail++; $display("FAIL walk_reset ped_pending got %b exp 0", ped_pending); end
  endtask

`ifdef EMERGENCY_PREEMPT_EN
  task automatic test_emergency();
    do_reset();
    req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    emerg = 1'b1;
    tick();
    n_tests++; if (phase !== 3'd2) begin n_fail++; $display("FAIL emerg_yellow phase got %0d exp 2", phase); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (phase !== 3'd0) begin n_fail++; $display("FAIL emerg_hold%0d phase got %0d exp 0", i, phase); end
    end
    emerg = 1'b0;
    tick();
    n_tests++; if (phase !== 3'd1) begin n_fail++; $display("FAIL emerg_release phase got %0d exp 1", phase); end
  endtask
`else
  task automatic test_emergency();
    do_reset();
    req_a = 1'b1;
    tick();
    tick();
    req_a = 1'b0;
    emerg = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (phase !== 3'd1) begin n_fail++; $display("FAIL emerg_ignored%0d phase got %0d exp 1", i, phase); end
    end
    emerg = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; ped_btn = 1'b0; emerg = 1'b0;
    test_reset();
    test_first_grant();
    test_min_green();
    test_long_hold();
    test_rotation();
    test_ped_relatch_and_reset();
    test_emergency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
